// File: rtl/inst_fifo_if.sv
// inst_fifo_if: bundle of the fetch-side push, issue-side pop and status
// signals of the instruction FIFO.
//   master : fetch/issue/control side (drives pushes, pops and flush)
//   slave  : the FIFO itself (drives show-ahead data, flags and occupancy)
// Signals: flush, flush_keep_head, write_en1/2, write_data1/2, read_en1/2,
//          read_data1/2, empty, almost_empty, full, count.
interface inst_fifo_if #(
  parameter int DEPTH = 16,
  parameter int DW    = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          flush_keep_head;
  logic          write_en1;
  logic          write_en2;
  logic [DW-1:0] write_data1;
  logic [DW-1:0] write_data2;
  logic          read_en1;
  logic          read_en2;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;
  logic          empty;
  logic          almost_empty;
  logic          full;
  logic [CW-1:0] count;

  modport master (
    output flush, flush_keep_head, write_en1, write_en2, write_data1,
           write_data2, read_en1, read_en2,
    input  read_data1, read_data2, empty, almost_empty, full, count
  );

  modport slave (
    input  flush, flush_keep_head, write_en1, write_en2, write_data1,
           write_data2, read_en1, read_en2,
    output read_data1, read_data2, empty, almost_empty, full, count
  );
endinterface

// File: rtl/inst_fifo.sv
// inst_fifo: dual-push / dual-pop show-ahead instruction queue between fetch
// and a two-way issue stage. Entries are {pc, inst}.
// Ports:
//   clk     - sole clock, rising edge
//   resetn  - asynchronous active-low reset (pointers/count only)
//   fifo_if - inst_fifo_if.slave: push/pop/flush controls in, show-ahead
//             head entries, status flags and occupancy out
module inst_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 64
) (
  input  logic        clk,
  input  logic        resetn,
  inst_fifo_if.slave  fifo_if
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] rd_r;
  logic [AW-1:0] wr_r;
  logic [CW-1:0] cnt_r;
  logic          empty_r;
  logic          almost_empty_r;
  logic          full_r;

  logic [1:0]    pop_s;
  logic [1:0]    push_s;
  logic [CW-1:0] remain_s;
  logic [AW-1:0] rd_nxt_s;
  logic [AW-1:0] wr_nxt_s;
  logic [CW-1:0] cnt_nxt_s;
  logic          wr_ok_s;

  // Effective pop/push counts; full_r reflects the pre-edge count so pops in
  // the same cycle never unblock a push.
  always_comb begin
    pop_s  = 2'd0;
    push_s = 2'd0;
    if (fifo_if.read_en1 && fifo_if.read_en2 && (cnt_r >= CW'(2))) begin
      pop_s = 2'd2;
    end else if (fifo_if.read_en1 && (cnt_r >= CW'(1))) begin
      pop_s = 2'd1;
    end else begin
      pop_s = 2'd0;
    end
    if (full_r) begin
      push_s = 2'd0;
    end else if (fifo_if.write_en1 && fifo_if.write_en2) begin
      push_s = 2'd2;
    end else if (fifo_if.write_en1) begin
      push_s = 2'd1;
    end else begin
      push_s = 2'd0;
    end
  end

  // Next pointers and occupancy; flush overrides every push.
  always_comb begin
    remain_s  = cnt_r - CW'(pop_s);
    rd_nxt_s  = rd_r;
    wr_nxt_s  = wr_r;
    cnt_nxt_s = cnt_r;
    if (fifo_if.flush) begin
      if (fifo_if.flush_keep_head) begin
        // The first entry surviving this cycle's pops becomes the delay slot.
        rd_nxt_s = rd_r + AW'(pop_s);
        if (remain_s != {CW{1'b0}}) begin
          cnt_nxt_s = CW'(1);
          wr_nxt_s  = rd_r + AW'(pop_s) + AW'(1);
        end else begin
          cnt_nxt_s = {CW{1'b0}};
          wr_nxt_s  = rd_r + AW'(pop_s);
        end
      end else begin
        rd_nxt_s  = rd_r;
        wr_nxt_s  = rd_r;
        cnt_nxt_s = {CW{1'b0}};
      end
    end else begin
      rd_nxt_s  = rd_r + AW'(pop_s);
      wr_nxt_s  = wr_r + AW'(push_s);
      cnt_nxt_s = cnt_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Pointer, occupancy and registered flag state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_r           <= {AW{1'b0}};
      wr_r           <= {AW{1'b0}};
      cnt_r          <= {CW{1'b0}};
      empty_r        <= 1'b1;
      almost_empty_r <= 1'b0;
      full_r         <= 1'b0;
    end else begin
      rd_r           <= rd_nxt_s;
      wr_r           <= wr_nxt_s;
      cnt_r          <= cnt_nxt_s;
      // Flags track the count register exactly, one decode ahead.
      empty_r        <= (cnt_nxt_s == {CW{1'b0}});
      almost_empty_r <= (cnt_nxt_s == CW'(1));
      full_r         <= (cnt_nxt_s >= CW'(DEPTH - 1));
    end
  end

  assign wr_ok_s = resetn && !fifo_if.flush && (push_s != 2'd0);

  // Entry storage; never cleared, only overwritten by accepted pushes.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem[wr_r] <= fifo_if.write_data1;
      if (push_s == 2'd2) begin
        mem[wr_r + AW'(1)] <= fifo_if.write_data2;
      end
    end
  end

  assign fifo_if.read_data1   = mem[rd_r];
  assign fifo_if.read_data2   = mem[rd_r + AW'(1)];
  assign fifo_if.empty        = empty_r;
  assign fifo_if.almost_empty = almost_empty_r;
  assign fifo_if.full         = full_r;
  assign fifo_if.count        = cnt_r;
endmodule

// File: tb/tb_inst_fifo.sv
module tb_inst_fifo;
  localparam int DEPTH = 16;
  localparam int DW    = 64;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;
  logic [DW-1:0] sb [$];

  inst_fifo_if #(.DEPTH(DEPTH), .DW(DW)) ifc ();

  inst_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .fifo_if (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = sb.size();
    check({tag, "_count"}, DW'(ifc.count), DW'(n));
    check({tag, "_empty"}, DW'(ifc.empty), DW'(n == 0));
    check({tag, "_aempty"}, DW'(ifc.almost_empty), DW'(n == 1));
    check({tag, "_full"}, DW'(ifc.full), DW'(n >= DEPTH - 1));
    if (n >= 1) check({tag, "_rd1"}, ifc.read_data1, sb[0]);
    if (n >= 2) check({tag, "_rd2"}, ifc.read_data2, sb[1]);
  endtask

  // One clock of stimulus: called at posedge+1, returns at next posedge+1.
  task automatic step(input string tag, input logic we1, input logic we2,
                      input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                      input logic re1, input logic re2,
                      input logic fl, input logic fkh);
    int n, pop, push;
    logic [DW-1:0] keep;
    n = sb.size();
    ifc.write_en1 = we1;  ifc.write_en2 = we2;
    ifc.write_data1 = d1; ifc.write_data2 = d2;
    ifc.read_en1 = re1;   ifc.read_en2 = re2;
    ifc.flush = fl;       ifc.flush_keep_head = fkh;
    #1;
    pop  = (re1 && re2 && n >= 2) ? 2 : ((re1 && n >= 1) ? 1 : 0);
    push = (n >= DEPTH - 1) ? 0 : ((we1 && we2) ? 2 : (we1 ? 1 : 0));
    for (int i = 0; i < pop; i++) begin
      keep = sb.pop_front();
      check({tag, "_popdata"}, (i == 0) ? ifc.read_data1 : ifc.read_data2, keep);
    end
    if (fl) begin
      if (fkh && sb.size() > 0) begin
        keep = sb[0];
        sb.delete();
        sb.push_back(keep);
      end else begin
        sb.delete();
      end
    end else begin
      if (push >= 1) sb.push_back(d1);
      if (push == 2) sb.push_back(d2);
    end
    @(posedge clk);
    #1;
    ifc.write_en1 = 1'b0; ifc.write_en2 = 1'b0;
    ifc.read_en1 = 1'b0;  ifc.read_en2 = 1'b0;
    ifc.flush = 1'b0;     ifc.flush_keep_head = 1'b0;
    check_state(tag);
  endtask

  initial begin
    logic [DW-1:0] a, b;
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    ifc.write_en1 = 1'b0; ifc.write_en2 = 1'b0;
    ifc.write_data1 = 64'd0; ifc.write_data2 = 64'd0;
    ifc.read_en1 = 1'b0;  ifc.read_en2 = 1'b0;
    ifc.flush = 1'b0;     ifc.flush_keep_head = 1'b0;
    #12;
    check_state("reset");
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Dual push after reset, show-ahead of both heads.
    a = 64'h0000_1000_0000_0013;
    b = 64'h0000_1004_0000_0093;
    step("dualpush", 1'b1, 1'b1, a, b, 1'b0, 1'b0, 1'b0, 1'b0);
    step("pop1", 1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("pop2_cnt1", 1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("pop_empty", 1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("we2_only", 1'b0, 1'b1, 64'hdead, 64'hbeef, 1'b0, 1'b0, 1'b0, 1'b0);
    step("push1", 1'b1, 1'b0, 64'h11, 64'hbad, 1'b0, 1'b0, 1'b0, 1'b0);
    step("re2_only", 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Fill to 15, then dual push + dual pop while full.
    for (int i = 0; i < 7; i++)
      step("fill", 1'b1, 1'b1, 64'h100 + 64'(2 * i), 64'h101 + 64'(2 * i), 1'b0, 1'b0, 1'b0, 1'b0);
    step("full_push", 1'b1, 1'b1, 64'hf0f0, 64'hf1f1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("full_pushpop", 1'b1, 1'b1, 64'hbad0, 64'hbad1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Wrap: push 2 every cycle, alternating pop 1 and pop 2.
    for (int i = 0; i < 40; i++)
      step("wrap", 1'b1, 1'b1, {32'h2000 + 32'(i), $urandom()}, {32'h3000 + 32'(i), $urandom()},
           1'b1, 1'(i % 2), 1'b0, 1'b0);
    for (int i = 0; i < 9; i++)
      step("drain", 1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Plain flush, then flush keeping head with X,Y,Z queued.
    step("push_pre", 1'b1, 1'b1, 64'h71, 64'h72, 1'b0, 1'b0, 1'b0, 1'b0);
    step("flush", 1'b1, 1'b1, 64'hbad2, 64'hbad3, 1'b1, 1'b0, 1'b1, 1'b0);
    step("xy", 1'b1, 1'b1, 64'hA1, 64'hA2, 1'b0, 1'b0, 1'b0, 1'b0);
    step("z", 1'b1, 1'b0, 64'hA3, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("fkh", 1'b1, 1'b0, 64'hA4, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    step("after_fkh", 1'b1, 1'b0, 64'hA5, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("fkh_r0", 1'b1, 1'b1, 64'hbad4, 64'hbad5, 1'b1, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle with five entries queued.
    step("five_a", 1'b1, 1'b1, 64'hC1, 64'hC2, 1'b0, 1'b0, 1'b0, 1'b0);
    step("five_b", 1'b1, 1'b1, 64'hC3, 64'hC4, 1'b0, 1'b0, 1'b0, 1'b0);
    step("five_c", 1'b1, 1'b0, 64'hC5, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    sb.delete();
    #1;
    check_state("async_rst");
    #4;
    resetn = 1'b1;
    ifc.write_en1 = 1'b1;
    ifc.write_data1 = 64'hD1;
    #1;
    check_state("post_rst");
    sb.push_back(64'hD1);
    @(posedge clk);
    #1;
    ifc.write_en1 = 1'b0;
    check_state("first_push");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
